// File: rtl/alu_issue_ctrl_pkg.sv
// Shared opcode constants, FSM state encoding and latency lookup for the
// EX-stage ALU issue controller.
package alu_issue_ctrl_pkg;

    localparam logic [4:0] ALU_OP_NOP  = 5'h00;
    localparam logic [4:0] ALU_OP_AND  = 5'h01;
    localparam logic [4:0] ALU_OP_OR   = 5'h02;
    localparam logic [4:0] ALU_OP_ADD  = 5'h03;
    localparam logic [4:0] ALU_OP_ADDU = 5'h04;
    localparam logic [4:0] ALU_OP_SUB  = 5'h05;
    localparam logic [4:0] ALU_OP_SUBU = 5'h06;
    localparam logic [4:0] ALU_OP_XOR  = 5'h07;
    localparam logic [4:0] ALU_OP_NOR  = 5'h08;
    localparam logic [4:0] ALU_OP_SLT  = 5'h09;
    localparam logic [4:0] ALU_OP_SLL  = 5'h0A;
    localparam logic [4:0] ALU_OP_SRL  = 5'h0B;
    localparam logic [4:0] ALU_OP_FADD = 5'h0C;
    localparam logic [4:0] ALU_OP_FSUB = 5'h0D;
    localparam logic [4:0] ALU_OP_SRA  = 5'h0E;
    localparam logic [4:0] ALU_OP_MUL  = 5'h0F;
    localparam logic [4:0] ALU_OP_DIV  = 5'h10;
    localparam logic [4:0] ALU_OP_CEQ  = 5'h11;
    localparam logic [4:0] ALU_OP_CLT  = 5'h12;
    localparam logic [4:0] ALU_OP_CLE  = 5'h13;
    localparam logic [4:0] ALU_OP_CUN  = 5'h14;
    localparam logic [4:0] ALU_OP_CULT = 5'h15;
    localparam logic [4:0] ALU_OP_LUI  = 5'h16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_t;

    // Cycles the ALU must see an op held; the multi-cycle latencies come
    // from the instantiating module's parameters.
    function automatic logic [5:0] op_lat(input logic [4:0] op,
                                          input logic [5:0] mul_lat,
                                          input logic [5:0] div_lat,
                                          input logic [5:0] fp_lat);
        logic [5:0] lat;
        lat = 6'd1;
        case (op)
            ALU_OP_MUL:              lat = mul_lat;
            ALU_OP_DIV:              lat = div_lat;
            ALU_OP_FADD, ALU_OP_FSUB: lat = fp_lat;
            default:                 lat = 6'd1;
        endcase
        return lat;
    endfunction

    function automatic logic is_fcmp(input logic [4:0] op);
        return (op >= ALU_OP_CEQ) && (op <= ALU_OP_CULT);
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// ID/EX issue handshake: ID offers a decoded op, EX accepts it when ready.
interface alu_issue_ctrl_if;
    logic        id_valid;
    logic        ex_ready;
    logic [4:0]  id_op;
    logic [63:0] id_op1;
    logic [63:0] id_op2;
    logic [4:0]  id_shamt;

    modport master (
        output id_valid, id_op, id_op1, id_op2, id_shamt,
        input  ex_ready
    );

    modport slave (
        input  id_valid, id_op, id_op1, id_op2, id_shamt,
        output ex_ready
    );
endinterface

// File: rtl/alu_issue_ctrl_exe_lat_counter.sv
// Down-counter holding the remaining ALU hold cycles of the current op.
module exe_lat_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [5:0] load_val,
    input  logic       dec,
    output logic       zero
);
    logic [5:0] cnt;

    // Load takes priority; decrement only while non-zero.
    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && (cnt != 6'd0))
            cnt <= cnt - 6'd1;
    end

    assign zero = (cnt == 6'd0);
endmodule

// File: rtl/alu_issue_ctrl.sv
// EX-stage sequencer around the combinational ALU: registers operands,
// holds them for the op latency, captures the result, owns HI/LO/FCC.
// Optional build macro ALU_OVF_TRAP_EN: overflow on ADD/SUB raises ex_ovf
// and zeroes ex_result instead of passing the wrapped result through.
//
// state   | meaning
// ST_IDLE | no op in flight, ready to accept
// ST_EXEC | op held on ALU inputs; captured when the counter reaches zero
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32,
    parameter int FP_LAT  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    alu_issue_ctrl_if.slave   id,
    output logic [4:0]        alu_operation,
    output logic [63:0]       alu_op1,
    output logic [63:0]       alu_op2,
    output logic [4:0]        alu_shamt,
    input  logic [63:0]       alu_result,
    input  logic              alu_zero,
    input  logic              alu_overflow,
    output logic              ex_valid,
    output logic [63:0]       ex_result,
    output logic              ex_zero,
    output logic              ex_ovf,
    output logic [31:0]       hi,
    output logic [31:0]       lo,
    output logic              fcc,
    output logic              div0
);
    state_t      state, state_nxt;
    logic        cnt_zero;
    logic        ex_ready;
    logic        accept, capture;
    logic        id_div0, div0_pend;
    logic [5:0]  lat_m1;
    logic        cnt_load, cnt_dec;
    logic [5:0]  cnt_val;
    logic [63:0] cap_result;
    logic        cap_zero, cap_ovf;

    assign id.ex_ready = ex_ready;

    // A DIV by zero is never issued to the ALU; it completes in one cycle.
    assign id_div0 = (id.id_op == ALU_OP_DIV) && (id.id_op2[31:0] == 32'd0);
    assign lat_m1  = id_div0 ? 6'd0
                   : op_lat(id.id_op, 6'(MUL_LAT), 6'(DIV_LAT), 6'(FP_LAT)) - 6'd1;

    exe_lat_counter u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Next state and handshake; flush beats both accept and capture.
    always_comb begin
        state_nxt = state;
        ex_ready  = (state == ST_IDLE) || cnt_zero;
        accept    = id.id_valid && ex_ready && !flush;
        capture   = (state == ST_EXEC) && cnt_zero && !flush;
        cnt_load  = accept || flush;
        cnt_val   = flush ? 6'd0 : lat_m1;
        cnt_dec   = (state == ST_EXEC) && !cnt_zero && !flush;
        if (flush)
            state_nxt = ST_IDLE;
        else if (accept)
            state_nxt = ST_EXEC;
        else if (capture)
            state_nxt = ST_IDLE;
    end

    // Capture value selection, including the div-by-zero and trap overrides.
    always_comb begin
        cap_result = alu_result;
        cap_zero   = alu_zero;
        cap_ovf    = alu_overflow;
        if (div0_pend) begin
            cap_result = '0;
            cap_zero   = 1'b1;
            cap_ovf    = 1'b0;
        end
`ifdef ALU_OVF_TRAP_EN
        else if (alu_overflow &&
                 ((alu_operation == ALU_OP_ADD) || (alu_operation == ALU_OP_SUB))) begin
            cap_result = '0;
            cap_ovf    = 1'b1;
        end
`endif
    end

    // ALU operand registers; the op code drops to NOP whenever nothing is held.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_operation <= ALU_OP_NOP;
            alu_op1       <= '0;
            alu_op2       <= '0;
            alu_shamt     <= '0;
            div0_pend     <= 1'b0;
        end else if (flush) begin
            alu_operation <= ALU_OP_NOP;
            div0_pend     <= 1'b0;
        end else if (accept) begin
            alu_operation <= id_div0 ? ALU_OP_NOP : id.id_op;
            alu_op1       <= id.id_op1;
            alu_op2       <= id.id_op2;
            alu_shamt     <= id.id_shamt;
            div0_pend     <= id_div0;
        end else if (capture) begin
            alu_operation <= ALU_OP_NOP;
            div0_pend     <= 1'b0;
        end
    end

    // Result capture and architectural HI/LO/FCC side effects.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid  <= 1'b0;
            ex_result <= '0;
            ex_zero   <= 1'b0;
            ex_ovf    <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            fcc       <= 1'b0;
            div0      <= 1'b0;
        end else begin
            ex_valid <= capture;
            div0     <= capture && div0_pend;
            if (capture) begin
                ex_result <= cap_result;
                ex_zero   <= cap_zero;
                ex_ovf    <= cap_ovf;
                if ((alu_operation == ALU_OP_MUL) || (alu_operation == ALU_OP_DIV)) begin
                    hi <= alu_result[63:32];
                    lo <= alu_result[31:0];
                end else if (is_fcmp(alu_operation)) begin
                    fcc <= alu_zero;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a behavioural ALU model.
module tb_alu_issue_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [4:0]  alu_operation;
    logic [63:0] alu_op1, alu_op2;
    logic [4:0]  alu_shamt;
    logic [63:0] alu_result;
    logic        alu_zero, alu_overflow;
    logic        ex_valid, ex_zero, ex_ovf, fcc, div0;
    logic [63:0] ex_result;
    logic [31:0] hi, lo;

    alu_issue_ctrl_if id_bus ();

    alu_issue_ctrl #(.MUL_LAT(4), .DIV_LAT(32), .FP_LAT(3)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .id(id_bus.slave),
        .alu_operation(alu_operation), .alu_op1(alu_op1), .alu_op2(alu_op2),
        .alu_shamt(alu_shamt), .alu_result(alu_result), .alu_zero(alu_zero),
        .alu_overflow(alu_overflow), .ex_valid(ex_valid), .ex_result(ex_result),
        .ex_zero(ex_zero), .ex_ovf(ex_ovf), .hi(hi), .lo(lo), .fcc(fcc), .div0(div0)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU (32-bit integer ops, fake FP add, raw-bit FP compares).
    logic [31:0] s32;
    always_comb begin
        s32          = '0;
        alu_result   = '0;
        alu_overflow = 1'b0;
        alu_zero     = 1'b0;
        case (alu_operation)
            5'h03: begin
                s32 = alu_op1[31:0] + alu_op2[31:0];
                alu_result = {32'h0, s32};
                alu_overflow = (alu_op1[31] == alu_op2[31]) && (s32[31] != alu_op1[31]);
            end
            5'h05: begin
                s32 = alu_op1[31:0] - alu_op2[31:0];
                alu_result = {32'h0, s32};
                alu_overflow = (alu_op1[31] != alu_op2[31]) && (s32[31] != alu_op1[31]);
            end
            5'h0C: alu_result = alu_op1 + alu_op2;
            5'h0F: alu_result = {32'h0, alu_op1[31:0]} * {32'h0, alu_op2[31:0]};
            5'h10: if (alu_op2[31:0] != 32'd0)
                       alu_result = {32'($signed(alu_op1[31:0]) % $signed(alu_op2[31:0])),
                                     32'($signed(alu_op1[31:0]) / $signed(alu_op2[31:0]))};
            default: alu_result = '0;
        endcase
        case (alu_operation)
            5'h11:   alu_zero = (alu_op1[31:0] == alu_op2[31:0]);
            5'h12:   alu_zero = (alu_op2[31:0] <  alu_op1[31:0]);
            5'h13:   alu_zero = (alu_op2[31:0] <= alu_op1[31:0]);
            5'h14, 5'h15: alu_zero = 1'b0;
            default: alu_zero = (alu_result == 64'd0);
        endcase
    end

    typedef struct {
        logic [63:0] res;
        logic        ovf;
        logic        d0;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        fcc;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int n_total = 0;
    int n_pass  = 0;
    logic [31:0] m_hi = '0, m_lo = '0;
    logic        m_fcc = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic push_exp(input int lat, input logic [63:0] eres, input logic eovf, input logic ed0);
        exp_t e;
        e.res = eres; e.ovf = eovf; e.d0 = ed0;
        e.hi = m_hi; e.lo = m_lo; e.fcc = m_fcc;
        e.cyc = cyc + lat + 1;
        q.push_back(e);
    endtask

    task automatic drive(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b);
        id_bus.id_valid = 1'b1;
        id_bus.id_op    = op;
        id_bus.id_op1   = a;
        id_bus.id_op2   = b;
        id_bus.id_shamt = 5'd0;
    endtask

    task automatic issue(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b,
                         input int lat, input logic [63:0] eres, input logic eovf, input logic ed0);
        @(negedge clk);
        chk("ex_ready_before_issue", 64'(id_bus.ex_ready), 64'd1);
        drive(op, a, b);
        push_exp(lat, eres, eovf, ed0);
        @(posedge clk);
        #1 id_bus.id_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            n_total++;
            $display("FAIL drain_timeout: %0d results still outstanding, required 0", q.size());
            q.delete();
        end
        @(negedge clk);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a result.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("div0_outside_ex_valid", 64'(div0 && !ex_valid), 64'd0);
            if (ex_valid) begin
                if (q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_ex_valid: ex_valid=1 result=%h, required no result", ex_result);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("ex_valid_cycle", 64'(cyc), 64'(e.cyc));
                    chk("ex_result", ex_result, e.res);
                    chk("ex_ovf", 64'(ex_ovf), 64'(e.ovf));
                    chk("div0", 64'(div0), 64'(e.d0));
                    chk("hi", 64'(hi), 64'(e.hi));
                    chk("lo", 64'(lo), 64'(e.lo));
                    chk("fcc", 64'(fcc), 64'(e.fcc));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        id_bus.id_valid = 1'b0;
        id_bus.id_op = '0; id_bus.id_op1 = '0; id_bus.id_op2 = '0; id_bus.id_shamt = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ex_ready", 64'(id_bus.ex_ready), 64'd1);
        chk("rst_alu_operation", 64'(alu_operation), 64'd0);
        chk("rst_ex_valid", 64'(ex_valid), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_fcc", 64'(fcc), 64'd0);
        rst_n = 1'b1;

        // ADD 7+5, single cycle.
        issue(5'h03, 64'd7, 64'd5, 1, 64'd12, 1'b0, 1'b0);
        drain();

        // MUL 0xFFFF_FFFF*2: stalls ID for three cycles.
        m_hi = 32'h1; m_lo = 32'hFFFF_FFFE;
        issue(5'h0F, 64'hFFFF_FFFF, 64'd2, 4, 64'h1_FFFF_FFFE, 1'b0, 1'b0);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("mul_ex_ready_stall", 64'(id_bus.ex_ready), 64'd0);
        end
        @(negedge clk);
        chk("mul_ex_ready_last", 64'(id_bus.ex_ready), 64'd1);
        drain();

        // DIV -7/2.
        m_hi = 32'hFFFF_FFFF; m_lo = 32'hFFFF_FFFD;
        issue(5'h10, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 32, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0);
        drain();

        // DIV 9/0: not issued, div0 pulse, HI/LO untouched.
        issue(5'h10, 64'd9, 64'd0, 1, 64'd0, 1'b0, 1'b1);
        @(negedge clk);
        chk("div0_alu_op_nop", 64'(alu_operation), 64'd0);
        drain();

        // FP compares.
        m_fcc = 1'b1;
        issue(5'h12, 64'h4000_0000, 64'h3F80_0000, 1, 64'd0, 1'b0, 1'b0);
        drain();
        m_fcc = 1'b0;
        issue(5'h11, 64'h3F80_0000, 64'h4000_0000, 1, 64'd0, 1'b0, 1'b0);
        drain();

        // Back-to-back single-cycle ops: ADD 1+2 then SUB 10-4.
        @(negedge clk);
        drive(5'h03, 64'd1, 64'd2);
        push_exp(1, 64'd3, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("b2b_ex_ready", 64'(id_bus.ex_ready), 64'd1);
        drive(5'h05, 64'd10, 64'd4);
        push_exp(1, 64'd6, 1'b0, 1'b0);
        @(posedge clk);
        #1 id_bus.id_valid = 1'b0;
        drain();

        // FP add latency 3, then an unknown op code.
        issue(5'h0C, 64'd100, 64'd23, 3, 64'd123, 1'b0, 1'b0);
        drain();
        issue(5'h1F, 64'd55, 64'd66, 1, 64'd0, 1'b0, 1'b0);
        drain();

        // DIV 100/7 flushed while the counter holds 10.
        issue(5'h10, 64'd100, 64'd7, 32, 64'd0, 1'b0, 1'b0);
        repeat (22) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        void'(q.pop_back());
        @(negedge clk);
        chk("flush_ex_ready", 64'(id_bus.ex_ready), 64'd1);
        chk("flush_alu_op_nop", 64'(alu_operation), 64'd0);
        repeat (40) @(negedge clk);
        chk("flush_hi_kept", 64'(hi), 64'hFFFF_FFFF);
        chk("flush_lo_kept", 64'(lo), 64'hFFFF_FFFD);

        // Flush beats a same-cycle offer.
        @(negedge clk);
        drive(5'h03, 64'd4, 64'd4);
        flush = 1'b1;
        @(posedge clk);
        #1;
        id_bus.id_valid = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_vs_accept_op", 64'(alu_operation), 64'd0);
        repeat (3) @(negedge clk);

        // ADD signed overflow.
`ifdef ALU_OVF_TRAP_EN
        issue(5'h03, 64'h7FFF_FFFF, 64'd1, 1, 64'd0, 1'b1, 1'b0);
`else
        issue(5'h03, 64'h7FFF_FFFF, 64'd1, 1, 64'h8000_0000, 1'b1, 1'b0);
`endif
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
